// File: rtl/dp_ram_port_ctrl.sv
// dp_ram_port_ctrl: dual-port RAM front-end, read-only port A and read/write port B, each with its own credits and response FIFO.
// Define DP_RAM_PORT_CTRL_FWD_EN to forward same-edge port B write bytes into a port A read of the same word.
module dp_ram_port_pipe #(
    parameter int          ADDR_W    = 17,
    parameter int          DATA_W    = 32,
    parameter int          READ_LAT  = 2,
    parameter int          TAG_W     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    input  logic              reqRead,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] addr,
    input  logic [TAG_W-1:0]  tag,
    input  logic [DATA_W-1:0] ramWord,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       rspAddr,
    output logic [TAG_W-1:0]  rspTag
);
    localparam int CRED = READ_LAT + 1;
    localparam int CW   = $clog2(CRED + 1);
    localparam int PW   = $clog2(CRED);
    localparam int LAST = READ_LAT - 1;

    logic [CW-1:0]     cnt, fifoCnt;
    logic [READ_LAT-1:0] pipeValid;
    logic [DATA_W-1:0] pipeData [READ_LAT];
    logic [ADDR_W-1:0] pipeAddr [READ_LAT];
    logic [TAG_W-1:0]  pipeTag  [READ_LAT];
    logic [DATA_W-1:0] fifoData [CRED];
    logic [ADDR_W-1:0] fifoAddr [CRED];
    logic [TAG_W-1:0]  fifoTag  [CRED];
    logic [PW-1:0]     wrPtr, rdPtr;
    logic              accRd, popRsp, fifoEmpty, push, fifoPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(CRED - 1)) ? '0 : p + 1'b1;
    endfunction

    assign reqReady  = cnt < CW'(CRED);
    assign accRd     = reqValid && reqReady && reqRead;
    assign fifoEmpty = fifoCnt == '0;
    assign rspValid  = !fifoEmpty || pipeValid[LAST];
    assign popRsp    = rspValid && rspReady;
    // The last pipeline stage bypasses the FIFO when it is empty and the consumer is ready.
    assign push      = pipeValid[LAST] && !(fifoEmpty && rspReady);
    assign fifoPop   = !fifoEmpty && rspReady;
    assign rdata     = !rspValid ? '0 : fifoEmpty ? pipeData[LAST] : fifoData[rdPtr];
    assign rspAddr   = !rspValid ? '0 : BASE_ADDR | 32'(fifoEmpty ? pipeAddr[LAST] : fifoAddr[rdPtr]);
    assign rspTag    = !rspValid ? '0 : fifoEmpty ? pipeTag[LAST] : fifoTag[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pipeValid <= '0;
            fifoCnt   <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
        end else begin
            cnt       <= cnt + CW'(accRd) - CW'(popRsp);
            pipeValid <= READ_LAT'({pipeValid, accRd});
            fifoCnt   <= fifoCnt + CW'(push) - CW'(fifoPop);
            if (push) wrPtr <= nextPtr(wrPtr);
            if (fifoPop) rdPtr <= nextPtr(rdPtr);
        end
    end

    always_ff @(posedge clk) begin
        pipeData[0] <= ramWord;
        pipeAddr[0] <= addr;
        pipeTag[0]  <= tag;
        for (int i = 1; i < READ_LAT; i++) begin
            pipeData[i] <= pipeData[i-1];
            pipeAddr[i] <= pipeAddr[i-1];
            pipeTag[i]  <= pipeTag[i-1];
        end
        if (push) begin
            fifoData[wrPtr] <= pipeData[LAST];
            fifoAddr[wrPtr] <= pipeAddr[LAST];
            fifoTag[wrPtr]  <= pipeTag[LAST];
        end
    end
endmodule

module dp_ram_port_ctrl #(
    parameter int          ADDR_W    = 17,
    parameter int          DATA_W    = 32,
    parameter int          READ_LAT  = 2,
    parameter int          TAG_W     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    localparam int         BYTES     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [TAG_W-1:0]  a_tag,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rdata,
    output logic [31:0]       a_rsp_addr,
    output logic [TAG_W-1:0]  a_rsp_tag,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [TAG_W-1:0]  b_tag,
    input  logic [BYTES-1:0]  b_wstrb,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rdata,
    output logic [31:0]       b_rsp_addr,
    output logic [TAG_W-1:0]  b_rsp_tag
);
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  aIdx, bIdx;
    logic [DATA_W-1:0] aWord, bWord;
    logic              bWrite, bWriteAcc;

    assign aIdx      = a_addr[ADDR_W-1:OFF_W];
    assign bIdx      = b_addr[ADDR_W-1:OFF_W];
    assign bWrite    = |b_wstrb;
    assign bWriteAcc = b_req_valid && b_req_ready && bWrite;
    assign bWord     = mem[bIdx];

`ifdef DP_RAM_PORT_CTRL_FWD_EN
    always_comb begin
        aWord = mem[aIdx];
        for (int i = 0; i < BYTES; i++)
            if (bWriteAcc && bIdx == aIdx && b_wstrb[i]) aWord[8*i +: 8] = b_wdata[8*i +: 8];
    end
`else
    // Read-first: a same-edge write lands after port A has captured the old word.
    assign aWord = mem[aIdx];
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++)
            if (bWriteAcc && b_wstrb[i]) mem[bIdx][8*i +: 8] <= b_wdata[8*i +: 8];
    end

    dp_ram_port_pipe #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .TAG_W(TAG_W), .BASE_ADDR(BASE_ADDR)
    ) portA (
        .clk(clk), .rst_n(rst_n),
        .reqValid(a_req_valid), .reqRead(1'b1), .reqReady(a_req_ready),
        .addr(a_addr), .tag(a_tag), .ramWord(aWord),
        .rspValid(a_rsp_valid), .rspReady(a_rsp_ready),
        .rdata(a_rdata), .rspAddr(a_rsp_addr), .rspTag(a_rsp_tag)
    );

    dp_ram_port_pipe #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .TAG_W(TAG_W), .BASE_ADDR(BASE_ADDR)
    ) portB (
        .clk(clk), .rst_n(rst_n),
        .reqValid(b_req_valid), .reqRead(!bWrite), .reqReady(b_req_ready),
        .addr(b_addr), .tag(b_tag), .ramWord(bWord),
        .rspValid(b_rsp_valid), .rspReady(b_rsp_ready),
        .rdata(b_rdata), .rspAddr(b_rsp_addr), .rspTag(b_rsp_tag)
    );
endmodule

// File: tb/tb_dp_ram_port_ctrl.sv
// tb_dp_ram_port_ctrl: directed stimulus with a queue scoreboard per port and a negedge response monitor.
module tb_dp_ram_port_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        a_req_valid = 0, a_req_ready, a_rsp_valid, a_rsp_ready = 1;
    logic [16:0] a_addr = 0, b_addr = 0;
    logic [3:0]  a_tag = 0, a_rsp_tag, b_tag = 0, b_rsp_tag, b_wstrb = 0;
    logic [31:0] a_rdata, a_rsp_addr, b_rdata, b_rsp_addr, b_wdata = 0;
    logic        b_req_valid = 0, b_req_ready, b_rsp_valid, b_rsp_ready = 1;

    int compared = 0, mismatched = 0;
    logic [67:0] aq[$], bq[$];

    dp_ram_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr), .a_tag(a_tag),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rdata(a_rdata),
        .a_rsp_addr(a_rsp_addr), .a_rsp_tag(a_rsp_tag),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr), .b_tag(b_tag),
        .b_wstrb(b_wstrb), .b_wdata(b_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rdata(b_rdata),
        .b_rsp_addr(b_rsp_addr), .b_rsp_tag(b_rsp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rsp_valid && a_rsp_ready) begin
            if (aq.size() == 0) chk("a_unexpected_rsp", 96'(a_rsp_tag), 96'hBAD);
            else chk("a_rsp", {a_rdata, a_rsp_addr, a_rsp_tag}, aq.pop_front());
        end else if (!a_rsp_valid) chk("a_idle_zero", {a_rdata, a_rsp_addr, a_rsp_tag}, 0);
        if (b_rsp_valid && b_rsp_ready) begin
            if (bq.size() == 0) chk("b_unexpected_rsp", 96'(b_rsp_tag), 96'hBAD);
            else chk("b_rsp", {b_rdata, b_rsp_addr, b_rsp_tag}, bq.pop_front());
        end else if (!b_rsp_valid) chk("b_idle_zero", {b_rdata, b_rsp_addr, b_rsp_tag}, 0);
    end

    task automatic aRead(input logic [16:0] ad, input logic [3:0] tg, input logic [31:0] ex, output bit acc);
        a_req_valid = 1; a_addr = ad; a_tag = tg;
        @(negedge clk); acc = a_req_ready;
        @(posedge clk); #1; a_req_valid = 0;
        if (acc) aq.push_back({ex, 32'h8000_0000 | 32'(ad), tg});
    endtask

    task automatic bOp(input logic [16:0] ad, input logic [3:0] tg, input logic [3:0] st,
                       input logic [31:0] wd, input logic [31:0] ex, output bit acc);
        b_req_valid = 1; b_addr = ad; b_tag = tg; b_wstrb = st; b_wdata = wd;
        @(negedge clk); acc = b_req_ready;
        @(posedge clk); #1; b_req_valid = 0; b_wstrb = 0;
        if (acc && st == 0) bq.push_back({ex, 32'h8000_0000 | 32'(ad), tg});
    endtask

    task automatic wr(input logic [16:0] ad, input logic [31:0] wd, input logic [3:0] st);
        bit acc;
        bOp(ad, 0, st, wd, 0, acc);
        chk("wr_accept", 96'(acc), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc, accB;
        int vc, firstV, lastV, nAcc;
        logic [31:0] sameExp;
        // reset state
        @(negedge clk);
        chk("rst_a_req_ready", 96'(a_req_ready), 1);
        chk("rst_b_req_ready", 96'(b_req_ready), 1);
        chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
        @(negedge clk); rst_n = 1;
        idle(1);

        // write then read, latency and base address
        wr(17'h10, 32'hDEAD_BEEF, 4'hF);
        aRead(17'h10, 4'h3, 32'hDEAD_BEEF, acc);
        chk("t1_accept", 96'(acc), 1);
        @(negedge clk); chk("t1_lat_early", 96'(a_rsp_valid), 0);
        @(negedge clk); chk("t1_lat_on", 96'(a_rsp_valid), 1);
        idle(4);

        // back-to-back B reads
        for (int i = 0; i < 4; i++) wr(17'(4 * i), 32'h1000_0000 + i, 4'hF);
        vc = 0; firstV = -1; lastV = -1;
        fork
            for (int i = 0; i < 4; i++) begin
                bOp(17'(4 * i), 4'(i + 1), 0, 0, 32'h1000_0000 + i, accB);
                chk("t2_b_ready", 96'(accB), 1);
            end
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (b_rsp_valid) begin
                    vc++;
                    if (firstV < 0) firstV = k;
                    lastV = k;
                end
            end
        join
        chk("t2_valid_cycles", 96'(vc), 4);
        chk("t2_consecutive", 96'(lastV - firstV), 3);
        idle(3);

        // B stalled: exactly CRED reads accepted while A keeps streaming
        b_rsp_ready = 0;
        nAcc = 0;
        fork
            for (int i = 0; i < 5; i++) begin
                bit accA;
                aRead(17'(4 * (i % 4)), 4'(8 + i), 32'h1000_0000 + 32'(i % 4), accA);
                chk("t3_a_sustain", 96'(accA), 1);
            end
            for (int i = 0; i < 5; i++) begin
                bOp(17'(4 * (i % 4)), 4'(i + 1), 0, 0, 32'h1000_0000 + 32'(i % 4), accB);
                chk("t3_b_accept_pattern", 96'(accB), 96'(i < 3));
                nAcc += int'(accB);
            end
        join
        chk("t3_b_accepted", 96'(nAcc), 3);
        bOp(17'h40, 0, 4'hF, 32'h5555_5555, 0, accB);
        chk("t3_write_refused", 96'(accB), 0);
        @(negedge clk); chk("t3_ready_low", 96'(b_req_ready), 0);
        @(posedge clk); #1; b_rsp_ready = 1;
        idle(5);
        chk("t3_ready_back", 96'(b_req_ready), 1);
        chk("t3_b_drained", 96'(bq.size()), 0);

        // byte strobes
        wr(17'h30, 32'h1122_3344, 4'hF);
        wr(17'h30, 32'hAABB_CCDD, 4'b0101);
        bOp(17'h30, 4'h6, 0, 0, 32'h11BB_33DD, accB);
        chk("t4_accept", 96'(accB), 1);
        idle(4);

        // same-edge A read / B write collision
        wr(17'h20, 32'h0, 4'hF);
`ifdef DP_RAM_PORT_CTRL_FWD_EN
        sameExp = 32'hFFFF_FFFF;
`else
        sameExp = 32'h0;
`endif
        fork
            aRead(17'h20, 4'h7, sameExp, acc);
            bOp(17'h20, 0, 4'hF, 32'hFFFF_FFFF, 0, accB);
        join
        chk("t5_both_accept", {acc, accB}, 2'b11);
        aRead(17'h20, 4'h8, 32'hFFFF_FFFF, acc);
        idle(4);

        // reset with reads in flight
        aRead(17'h10, 4'h1, 32'hDEAD_BEEF, acc);
        aRead(17'h10, 4'h2, 32'hDEAD_BEEF, acc);
        rst_n = 0;
        #1;
        chk("t6_rsp_valid_low", 96'(a_rsp_valid), 0);
        chk("t6_req_ready_high", 96'(a_req_ready), 1);
        aq.delete();
        idle(3);
        @(negedge clk); rst_n = 1;
        idle(6);
        aRead(17'h10, 4'h9, 32'hDEAD_BEEF, acc);
        bOp(17'h30, 4'hA, 0, 0, 32'h11BB_33DD, accB);
        chk("t6_accept", {acc, accB}, 2'b11);

        // bounded drain
        for (int k = 0; k < 20 && (aq.size() != 0 || bq.size() != 0); k++) @(posedge clk);
        idle(2);
        chk("drain_a", 96'(aq.size()), 0);
        chk("drain_b", 96'(bq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
